// File: rtl/csa_pkg.sv
// Shared constants and FSM encoding for the carry-save resolver.
// W      : operand / result width
// CHUNK  : bits resolved per cycle
// NCHUNK : number of chunks, ceil(W/CHUNK)
// LAST_W : width of the final (narrower) chunk
package csa_pkg;

    localparam int W      = 82;
    localparam int CHUNK  = 21;
    localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
    localparam int LAST_W = W - (NCHUNK - 1) * CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cpa_chunk.sv
// Combinational CHUNK-bit carry-propagate adder slice.
// a_i, b_i : chunk operands (narrow chunks arrive zero-extended)
// ci_i     : carry in
// sum_o    : chunk sum
// co_o     : carry out of the full CHUNK-bit slice
module cpa_chunk #(
    parameter int CHUNK = 21
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o
);

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (CHUNK+1)'(ci_i);

endmodule

// File: rtl/csa_resolve_82.sv
// Resolves a carry-save pair (c_in, s_in) into a binary sum, CHUNK bits
// per cycle, through a single shared chunk adder.
// clk, rst            : clock, asynchronous active-high reset
// in_valid / in_ready : operand handshake (accepted only in IDLE)
// c_in, s_in          : carry and sum vectors of the redundant operand
// out_valid/out_ready : result handshake (presented only in DONE)
// sum_out, cout       : (c_in + s_in) mod 2^W and bit W of the sum
//
// state | meaning
// IDLE  | waiting for an operand pair, last result held on sum_out
// ADD   | resolving chunk idx_q, one chunk per cycle
// DONE  | result presented until out_ready
module csa_resolve_82 import csa_pkg::*; #(
    parameter int W     = csa_pkg::W,
    parameter int CHUNK = csa_pkg::CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] c_in,
    input  logic [W-1:0] s_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_out,
    output logic         cout
);

    localparam int NCH   = (W + CHUNK - 1) / CHUNK;
    localparam int LASTW = W - (NCH - 1) * CHUNK;
    localparam int PAD_W = NCH * CHUNK;

    state_t       state_q;
    logic [W-1:0] c_q, s_q;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic [1:0]   idx_q;
    logic         carry_q;

    logic [PAD_W-1:0] c_pad, s_pad;
    logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
    logic             chunk_co;
    logic [CHUNK:0]   chunk_ext;
    logic             last_carry;

    // Padding bits above W are zero, so the final chunk is zero-extended.
    assign c_pad = PAD_W'(c_q);
    assign s_pad = PAD_W'(s_q);

    always_comb begin
        a_chunk = c_pad[int'(idx_q)*CHUNK +: CHUNK];
        b_chunk = s_pad[int'(idx_q)*CHUNK +: CHUNK];
    end

    cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i   (a_chunk),
        .b_i   (b_chunk),
        .ci_i  (carry_q),
        .sum_o (chunk_sum),
        .co_o  (chunk_co)
    );

    // The final chunk is only LASTW bits wide; its carry sits at bit LASTW
    // of the extended chunk result rather than at the slice carry-out.
    assign chunk_ext  = {chunk_co, chunk_sum};
    assign last_carry = chunk_ext[LASTW];

    always_comb begin
        acc_d = acc_q;
        for (int b = 0; b < W; b++) begin
            if (b / CHUNK == int'(idx_q)) begin
                acc_d[b] = chunk_sum[b % CHUNK];
            end
        end
    end

    // Partial chunks accumulate in acc_q; sum_q only changes on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        c_q     <= c_in;
                        s_q     <= s_in;
                        idx_q   <= 2'd0;
                        carry_q <= 1'b0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    acc_q   <= acc_d;
                    carry_q <= chunk_co;
                    idx_q   <= idx_q + 2'd1;
                    if (idx_q == 2'(NCH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= last_carry;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum_out   = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_csa_resolve_82.sv
// Self-checking bench for csa_resolve_82: directed corner cases, a reset
// in the middle of an addition, and a long randomized run against an
// exact (W+1)-bit arithmetic reference.
module tb_csa_resolve_82;

    localparam int W = 82;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] c_in = '0;
    logic [W-1:0] s_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;

    logic [W:0] prev_res = '0;

    always #5 clk = ~clk;

    csa_resolve_82 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // One full transaction: offer, watch latency, verify, stall, release.
    task automatic do_op(input logic [W-1:0] c, input logic [W-1:0] s,
                         input int hold, input bit quiet);
        logic [W:0] exp;
        int lat;
        exp = {1'b0, c} + {1'b0, s};
        @(negedge clk);
        if (!quiet) chk("ready_before_accept", {82'd0, in_ready}, 83'd1);
        in_valid = 1'b1;
        c_in = c;
        s_in = s;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            // Operands and in_valid are scrambled while the add is in flight.
            in_valid = $urandom_range(0, 1);
            c_in = rnd_w();
            s_in = rnd_w();
            chk("hold_prev_result", {cout, sum_out}, prev_res);
            chk("busy_not_ready", {82'd0, in_ready}, 83'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 83'(lat), 83'd4);
        chk("result", {cout, sum_out}, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            c_in = rnd_w();
            chk("stall_valid", {82'd0, out_valid}, 83'd1);
            chk("stall_stable", {cout, sum_out}, exp);
            chk("stall_not_ready", {82'd0, in_ready}, 83'd0);
        end
        // in_valid stays high through the handshake: it must not be taken.
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("release_idle", {81'd0, in_ready, out_valid}, 83'b10);
        chk("idle_hold_result", {cout, sum_out}, exp);
        prev_res = exp;
    endtask

    initial begin
        logic [W-1:0] ones;
        int seen;
        ones = '1;

        #1 rst = 1'b1;
        #2;
        chk("rst_outputs", {79'd0, in_ready, out_valid, cout, |sum_out}, 83'b1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {82'd0, in_ready}, 83'd1);

        do_op('0, '0, 0, 1'b0);
        do_op(82'd1, 82'h1F_FFFF, 1, 1'b0);
        do_op(ones, 82'd1, 0, 1'b0);
        do_op(ones, ones, 10, 1'b0);

        // Reset in the middle of ADD, with idx at 2.
        @(negedge clk);
        in_valid = 1'b1;
        c_in = rnd_w();
        s_in = rnd_w();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midadd_rst_outputs", {79'd0, in_ready, out_valid, cout, |sum_out}, 83'b1000);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_valid_after_rst", 83'(seen), 83'd0);
        chk("ready_after_midrst", {82'd0, in_ready}, 83'd1);
        prev_res = '0;
        do_op(ones, 82'd1, 2, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] c, s;
            c = rnd_w();
            s = rnd_w();
            case ($urandom_range(0, 7))
                0: c = ones;
                1: s = ~c;
                default: ;
            endcase
            do_op(c, s, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csa_resolve_82.md
CSA_RESOLVE_82 -- requirements
Module: csa_resolve_82

Interface
REQ-001 The parameter W SHALL default to 82 and set the operand and result width in bits.
REQ-002 The parameter CHUNK SHALL default to 21 and set the bits resolved per cycle; NCHUNK = ceil(W/CHUNK) = 4.
REQ-003 The port clk SHALL be an input of width 1 and be the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input of width 1 and be an asynchronous, active-high reset.
REQ-005 The port in_valid SHALL be an input of width 1 and indicate that a redundant operand pair is offered.
REQ-006 The port in_ready SHALL be an output of width 1 and indicate that the block accepts an operand pair.
REQ-007 The port c_in SHALL be an input of width W and carry the carry vector of the carry-save pair.
REQ-008 The port s_in SHALL be an input of width W and carry the sum vector of the carry-save pair.
REQ-009 The port out_valid SHALL be an output of width 1 and indicate that a resolved result is presented.
REQ-010 The port out_ready SHALL be an input of width 1 and indicate that the consumer takes the result.
REQ-011 The port sum_out SHALL be an output of width W and carry (c_in + s_in) mod 2^W.
REQ-012 The port cout SHALL be an output of width 1 and carry bit W of c_in + s_in.

Function
REQ-013 The block SHALL implement a three-state FSM with the states IDLE, ADD and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, when in_valid=1, the block SHALL register c_in and s_in, clear the chunk index and carry register, and move to ADD.
REQ-016 In ADD, each cycle SHALL add operand bits [idx*CHUNK +: CHUNK] plus the carry register, write those sum bits, latch the chunk carry-out and increment idx.
REQ-017 The last chunk SHALL be W-(NCHUNK-1)*CHUNK = 19 bits wide; its carry-out SHALL be taken from its own MSB position and become cout.
REQ-018 After the chunk with idx = NCHUNK-1 completes, the FSM SHALL enter DONE; out_valid SHALL rise exactly NCHUNK = 4 cycles after the accepting edge.
REQ-019 In DONE, sum_out and cout SHALL stay stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-020 The block SHALL NOT accept new input in the same cycle as the output handshake; throughput is one result per 6 cycles minimum.
REQ-021 In ADD and DONE, in_valid, c_in and s_in SHALL be ignored, and operand changes SHALL NOT affect the result in flight.
REQ-022 Arithmetic SHALL be unsigned, and sum_out together with cout SHALL equal the exact (W+1)-bit sum of c_in and s_in.
REQ-023 sum_out SHALL hold the last completed result in IDLE and ADD; partial chunks SHALL NOT be exposed as valid.

Reset
REQ-024 While rst=1, the state SHALL be IDLE, with in_ready=1, out_valid=0, sum_out=0, cout=0, idx=0 and the carry register=0, irrespective of clk.
REQ-025 A reset asserted in ADD or DONE SHALL discard the operation in flight, and no out_valid pulse SHALL follow the reset.
REQ-026 in_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-027 A shared package csa_pkg SHALL hold W, CHUNK, NCHUNK, the last-chunk width and the FSM state encoding (IDLE=0, ADD=1, DONE=2).
REQ-028 A single sub-module cpa_chunk SHALL be instantiated once: a CHUNK-bit combinational adder with carry-in and carry-out, with the last chunk zero-extended.
REQ-029 Operand, result, idx (2 bits) and carry registers SHALL reside in csa_resolve_82; no other hierarchy is permitted.

Verification
REQ-030 Scenario: c=0, s=0 accepted -> out_valid 4 cycles later with sum_out=0 and cout=0.
REQ-031 Scenario: c=1, s=2^21-1 -> sum_out=2^21 and cout=0, confirming the carry crosses the chunk-0/1 boundary.
REQ-032 Scenario: c=2^82-1, s=1 -> sum_out=0 and cout=1, confirming the carry ripples through all 4 chunks.
REQ-033 Scenario: out_ready held low 10 cycles -> out_valid stays 1, sum_out stays stable and in_ready stays 0; release -> IDLE on the next edge.
REQ-034 Scenario: rst pulsed mid-ADD (idx=2) -> outputs follow REQ-024 immediately, no out_valid pulse, and the next operand is resolved correctly.
REQ-035 Scenario: 1000 random (c,s) pairs with random out_ready -> each result equals the (W+1)-bit reference sum c+s, checked in order.
